peso_aquisicao: RTL

Weight-acquisition front end of the digital scale. It accepts raw load-cell samples over a valid/ready handshake and averages them in blocks. It applies tare, saturation and stability detection. It produces the `weight_kg` word consumed by the price calculator, together with a one-cycle `weight_valid` strobe and `stable`/`overload` flags for the display.

---
 rtl/balanca_pkg.sv | 16 +
 rtl/peso_media.sv | 45 ++++
 rtl/peso_aquisicao.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/balanca_pkg.sv
// Shared scale types and default constants.
// Keeps acquisition, price and display widths in agreement.
package balanca_pkg;

  localparam int W            = 16;
  localparam int N_LOG2       = 3;
  localparam int MAX_RAW      = 50000;
  localparam int TOL          = 2;
  localparam int STABLE_COUNT = 4;

  typedef enum logic {
    ST_ACC,
    ST_UPD
  } state_e;

endpackage

// File: rtl/peso_media.sv
// Block accumulator: sums 2^N_LOG2 accepted samples.
// Ports: add_i accept, clr_i clear, data_i sample; done_o last, avg_o mean.
module peso_media #(
  parameter int W      = 16,
  parameter int N_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         add_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         done_o,
  output logic [W-1:0] avg_o
);

  logic [W+N_LOG2-1:0] acc_q, acc_d;
  logic [N_LOG2-1:0]   cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + {{N_LOG2{1'b0}}, data_i};
      cnt_d = cnt_q + 1'b1;
    end
  end

  // last sample of the block is being accepted now
  assign done_o = add_i && (cnt_q == '1);
  assign avg_o  = W'(acc_q >> N_LOG2);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/peso_aquisicao.sv
// Scale front end: block average, tare, overload, stability.
// Ports: adc_* sample handshake, tare request; weight_kg/valid, flags.
module peso_aquisicao #(
  parameter int W            = balanca_pkg::W,
  parameter int N_LOG2       = balanca_pkg::N_LOG2,
  parameter int MAX_RAW      = balanca_pkg::MAX_RAW,
  parameter int TOL          = balanca_pkg::TOL,
  parameter int STABLE_COUNT = balanca_pkg::STABLE_COUNT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adc_valid,
  input  logic [W-1:0] adc_data,
  output logic         adc_ready,
  input  logic         tare,
  output logic [W-1:0] weight_kg,
  output logic         weight_valid,
  output logic         stable,
  output logic         overload
);

  import balanca_pkg::*;

  localparam int SCW = $clog2(STABLE_COUNT + 1);

  state_e state_q, state_d;

  logic         accept;
  logic         upd;
  logic         done;
  logic [W-1:0] avg;
  logic         ov;
  logic [W-1:0] diff;
  logic         steady;

  logic [W-1:0]   weight_q, weight_d;
  logic           wv_q, wv_d;
  logic           stable_q, stable_d;
  logic           ovl_q, ovl_d;
  logic [W-1:0]   offset_q, offset_d;
  logic [W-1:0]   prev_q, prev_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic [SCW-1:0] scnt_inc;
  logic           pend_q, pend_d;

  assign adc_ready = (state_q == ST_ACC) && !rst;
  assign accept    = adc_valid && adc_ready;
  assign upd       = (state_q == ST_UPD);

  peso_media #(
    .W      (W),
    .N_LOG2 (N_LOG2)
  ) u_media (
    .clk    (clk),
    .rst    (rst),
    .add_i  (accept),
    .clr_i  (upd),
    .data_i (adc_data),
    .done_o (done),
    .avg_o  (avg)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACC: if (done) state_d = ST_UPD;
      ST_UPD: state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  assign ov     = avg > W'(MAX_RAW);
  assign diff   = (avg >= prev_q) ? avg - prev_q : prev_q - avg;
  assign steady = diff <= W'(TOL);
  assign scnt_inc = (scnt_q == SCW'(STABLE_COUNT))
                  ? scnt_q : scnt_q + 1'b1;

  always_comb begin
    weight_d = weight_q;
    wv_d     = 1'b0;
    stable_d = stable_q;
    ovl_d    = ovl_q;
    offset_d = offset_q;
    prev_d   = prev_q;
    scnt_d   = scnt_q;
    // a tare request is latched until an update can honour it
    pend_d   = pend_q | tare;
    if (upd) begin
      wv_d   = 1'b1;
      prev_d = avg;
      if (ov) begin
        ovl_d    = 1'b1;
        stable_d = 1'b0;
        scnt_d   = '0;
      end else if (pend_q || tare) begin
        ovl_d    = 1'b0;
        offset_d = avg;
        weight_d = '0;
        scnt_d   = '0;
        stable_d = 1'b0;
        pend_d   = 1'b0;
      end else begin
        ovl_d    = 1'b0;
        weight_d = (avg > offset_q) ? avg - offset_q : '0;
        scnt_d   = steady ? scnt_inc : '0;
        stable_d = (scnt_d == SCW'(STABLE_COUNT));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ACC;
      weight_q <= '0;
      wv_q     <= 1'b0;
      stable_q <= 1'b0;
      ovl_q    <= 1'b0;
      offset_q <= '0;
      prev_q   <= '0;
      scnt_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      weight_q <= weight_d;
      wv_q     <= wv_d;
      stable_q <= stable_d;
      ovl_q    <= ovl_d;
      offset_q <= offset_d;
      prev_q   <= prev_d;
      scnt_q   <= scnt_d;
      pend_q   <= pend_d;
    end
  end

  assign weight_kg    = weight_q;
  assign weight_valid = wv_q;
  assign stable       = stable_q;
  assign overload     = ovl_q;

endmodule
